// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM responder shared by instruction fetch and data access.
// Optional watchdog abort on a stalled RAM is built when MEM_ARBITER_TIMEOUT_EN is defined.
module mem_arbiter #(
    parameter int unsigned DATA_PRIORITY  = 1,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        nrst,

    input  logic        imem_ren,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_load,
    output logic        ihit,

    input  logic        dmem_ren,
    input  logic        dmem_wen,
    input  logic [31:0] dmem_addr,
    input  logic [2:0]  dmem_width,
    input  logic [31:0] dmem_store,
    output logic [31:0] dmem_load,
    output logic        dhit,
    output logic        misalign_err,
    output logic        bus_err,

    output logic [29:0] ram_addr,
    output logic        ram_ren,
    output logic        ram_wen,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_be,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ready
);

    // state | meaning
    // IDLE  | no access in flight; grant one pending request
    // IBUSY | fetch strobe on the RAM, waiting for ram_ready
    // DBUSY | data strobe on the RAM, waiting for ram_ready
    // RESP  | one-cycle hit pulse with response data, then back to IDLE
    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, RESP} state_t;

    state_t      state;
    logic        lat_wr;
    logic [1:0]  lat_off;
    logic [1:0]  lat_width;

    logic        dmem_req;
    logic        grant_d;
    logic        grant_i;
    logic [1:0]  d_width;
    logic        d_misaligned;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic [31:0] rd_shifted;
    logic [31:0] load_val;

    logic        unused_bits;
    assign unused_bits = ^{dmem_width[2], imem_addr[1:0]};

    always_comb begin
        dmem_req     = dmem_ren | dmem_wen;
        grant_d      = dmem_req & ((DATA_PRIORITY != 0) | ~imem_ren);
        grant_i      = imem_ren & ~grant_d;
        d_width      = dmem_width[1:0];
        // encoding 11 behaves as a word access
        d_misaligned = ((d_width == 2'b01) && dmem_addr[0]) ||
                       (d_width[1] && (dmem_addr[1:0] != 2'b00));
    end

    always_comb begin
        d_be    = 4'b1111;
        d_wdata = dmem_store;
        if (dmem_wen) begin
            case (d_width)
                2'b00: begin
                    d_be    = 4'b0001 << dmem_addr[1:0];
                    d_wdata = {4{dmem_store[7:0]}};
                end
                2'b01: begin
                    d_be    = dmem_addr[1] ? 4'b1100 : 4'b0011;
                    d_wdata = {2{dmem_store[15:0]}};
                end
                default: begin
                    d_be    = 4'b1111;
                    d_wdata = dmem_store;
                end
            endcase
        end
    end

    always_comb begin
        rd_shifted = ram_rdata >> {lat_off, 3'b000};
        case (lat_width)
            2'b00:   load_val = {24'h0, rd_shifted[7:0]};
            2'b01:   load_val = {16'h0, rd_shifted[15:0]};
            default: load_val = rd_shifted;
        endcase
    end

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam int          WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
    logic [WD_W-1:0] wdog;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign bus_err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= IDLE;
            lat_wr       <= 1'b0;
            lat_off      <= 2'b00;
            lat_width    <= 2'b00;
            imem_load    <= 32'h0;
            dmem_load    <= 32'h0;
            ihit         <= 1'b0;
            dhit         <= 1'b0;
            misalign_err <= 1'b0;
            ram_addr     <= 30'h0;
            ram_ren      <= 1'b0;
            ram_wen      <= 1'b0;
            ram_wdata    <= 32'h0;
            ram_be       <= 4'h0;
`ifdef MEM_ARBITER_TIMEOUT_EN
            bus_err      <= 1'b0;
            wdog         <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef MEM_ARBITER_TIMEOUT_EN
                    wdog <= '0;
`endif
                    if (grant_d) begin
                        lat_wr    <= dmem_wen;
                        lat_off   <= dmem_addr[1:0];
                        lat_width <= d_width;
                        ram_addr  <= dmem_addr[31:2];
                        if (d_misaligned) begin
                            // rejected without touching the RAM
                            dhit         <= 1'b1;
                            misalign_err <= 1'b1;
                            dmem_load    <= 32'h0;
                            state        <= RESP;
                        end else begin
                            ram_ren   <= ~dmem_wen;
                            ram_wen   <= dmem_wen;
                            ram_be    <= d_be;
                            ram_wdata <= d_wdata;
                            state     <= DBUSY;
                        end
                    end else if (grant_i) begin
                        lat_wr    <= 1'b0;
                        lat_off   <= 2'b00;
                        lat_width <= 2'b10;
                        ram_addr  <= imem_addr[31:2];
                        ram_ren   <= 1'b1;
                        ram_be    <= 4'b1111;
                        state     <= IBUSY;
                    end
                end

                IBUSY, DBUSY: begin
                    if (ram_ready) begin
                        ram_ren <= 1'b0;
                        ram_wen <= 1'b0;
                        state   <= RESP;
                        if (state == IBUSY) begin
                            ihit      <= 1'b1;
                            imem_load <= ram_rdata;
                        end else begin
                            dhit      <= 1'b1;
                            dmem_load <= lat_wr ? 32'h0 : load_val;
                        end
                    end
`ifdef MEM_ARBITER_TIMEOUT_EN
                    else if (wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        ram_ren <= 1'b0;
                        ram_wen <= 1'b0;
                        bus_err <= 1'b1;
                        state   <= RESP;
                        if (state == IBUSY) begin
                            ihit      <= 1'b1;
                            imem_load <= ERR_DATA;
                        end else begin
                            dhit      <= 1'b1;
                            dmem_load <= ERR_DATA;
                        end
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
`endif
                end

                RESP: begin
                    ihit         <= 1'b0;
                    dhit         <= 1'b0;
                    misalign_err <= 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
                    bus_err      <= 1'b0;
`endif
                    state        <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner sequences, random traffic.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        nrst;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic [31:0] imem_load;
    logic        ihit;
    logic        dmem_ren;
    logic        dmem_wen;
    logic [31:0] dmem_addr;
    logic [2:0]  dmem_width;
    logic [31:0] dmem_store;
    logic [31:0] dmem_load;
    logic        dhit;
    logic        misalign_err;
    logic        bus_err;
    logic [29:0] ram_addr;
    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic [31:0] ram_rdata;
    logic        ram_ready;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(.DATA_PRIORITY(1), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .nrst(nrst),
        .imem_ren(imem_ren), .imem_addr(imem_addr), .imem_load(imem_load), .ihit(ihit),
        .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
        .dmem_width(dmem_width), .dmem_store(dmem_store), .dmem_load(dmem_load),
        .dhit(dhit), .misalign_err(misalign_err), .bus_err(bus_err),
        .ram_addr(ram_addr), .ram_ren(ram_ren), .ram_wen(ram_wen),
        .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_rdata(ram_rdata), .ram_ready(ram_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_fetch;
        bit          ren;
        bit          wen;
        logic [31:0] addr;
        logic [2:0]  width;
        logic [31:0] store;
        logic [31:0] rdata;
        int          lat;
        logic [29:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_load;
        bit          e_mis;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: access size in bytes and lane arithmetic from first principles.
    function automatic int m_size(input logic [2:0] w);
        case (w[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input int size, input int off, input bit wr);
        int v;
        if (!wr) return 4'hF;
        v = ((1 << size) - 1) << off;
        return 4'(v);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] s, input int size);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = s[8*(i % size) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] d, input int size, input int off);
        logic [31:0] r;
        r = 32'h0;
        for (int j = 0; j < size; j++) r[8*j +: 8] = d[8*(off + j) +: 8];
        return r;
    endfunction

    // Starts at a falling edge with the arbiter idle; ends at the falling edge of the following IDLE cycle.
    task automatic run_txn(input vec_t v, input string tag);
        bit wr;
        wr = !v.is_fetch && v.wen;
        if (v.is_fetch) begin
            imem_ren  = 1'b1;
            imem_addr = v.addr;
        end else begin
            dmem_ren   = v.ren;
            dmem_wen   = v.wen;
            dmem_addr  = v.addr;
            dmem_width = v.width;
            dmem_store = v.store;
        end
        @(negedge clk);
        imem_ren = 1'b0;
        dmem_ren = 1'b0;
        dmem_wen = 1'b0;
        if (v.e_mis) begin
            check({tag, " mis dhit"}, 32'(dhit), 32'd1);
            check({tag, " mis err"}, 32'(misalign_err), 32'd1);
            check({tag, " mis no strobe"}, 32'({ram_ren, ram_wen}), 32'd0);
            check({tag, " mis ihit"}, 32'(ihit), 32'd0);
        end else begin
            for (int c = 1; c <= v.lat; c++) begin
                check({tag, " ram_ren"}, 32'(ram_ren), 32'(!wr));
                check({tag, " ram_wen"}, 32'(ram_wen), 32'(wr));
                check({tag, " ram_addr"}, 32'(ram_addr), 32'(v.e_addr));
                check({tag, " ram_be"}, 32'(ram_be), 32'(v.e_be));
                if (wr) check({tag, " ram_wdata"}, ram_wdata, v.e_wdata);
                check({tag, " early hit"}, 32'({ihit, dhit}), 32'd0);
                if (c == v.lat) begin
                    ram_ready = 1'b1;
                    ram_rdata = v.rdata;
                end
                @(negedge clk);
            end
            ram_ready = 1'b0;
            ram_rdata = $urandom;
            check({tag, " ihit"}, 32'(ihit), 32'(v.is_fetch));
            check({tag, " dhit"}, 32'(dhit), 32'(!v.is_fetch));
            check({tag, " strobe off"}, 32'({ram_ren, ram_wen}), 32'd0);
            check({tag, " err flags"}, 32'({misalign_err, bus_err}), 32'd0);
            if (v.is_fetch) check({tag, " imem_load"}, imem_load, v.e_load);
            else            check({tag, " dmem_load"}, dmem_load, v.e_load);
        end
        @(negedge clk);
        check({tag, " hit one cycle"}, 32'({ihit, dhit, misalign_err}), 32'd0);
    endtask

    initial begin
        vec_t rv;
        int   size;
        int   off;
        int   hit_at;

        vecs[0] = '{1, 0, 0, 32'h0000_0100, 3'd0, 32'h0, 32'h0000_0013, 3, 30'h40, 4'hF, 32'h0, 32'h0000_0013, 0};
        vecs[1] = '{0, 1, 0, 32'h0000_0203, 3'd0, 32'h0, 32'hAABB_CCDD, 1, 30'h80, 4'hF, 32'h0, 32'h0000_00AA, 0};
        vecs[2] = '{0, 1, 0, 32'h0000_0202, 3'd1, 32'h0, 32'hAABB_CCDD, 2, 30'h80, 4'hF, 32'h0, 32'h0000_AABB, 0};
        vecs[3] = '{0, 0, 1, 32'h0000_0302, 3'd1, 32'h1234_5678, 32'hFFFF_FFFF, 1, 30'hC0, 4'hC, 32'h5678_5678, 32'h0, 0};
        vecs[4] = '{0, 1, 0, 32'h0000_0101, 3'd2, 32'h0, 32'h0, 1, 30'h40, 4'hF, 32'h0, 32'h0, 1};
        vecs[5] = '{0, 1, 0, 32'h0000_0400, 3'd3, 32'h0, 32'hCAFE_F00D, 4, 30'h100, 4'hF, 32'h0, 32'hCAFE_F00D, 0};
        vecs[6] = '{0, 1, 1, 32'h0000_0501, 3'd4, 32'h0000_0099, 32'h1111_1111, 2, 30'h140, 4'h2, 32'h9999_9999, 32'h0, 0};
        vecs[7] = '{0, 0, 1, 32'h0000_0203, 3'd1, 32'hABCD_EF01, 32'h0, 1, 30'h80, 4'hF, 32'h0, 32'h0, 1};
        vecs[8] = '{0, 1, 0, 32'h0000_0006, 3'd1, 32'h0, 32'h1122_3344, 1, 30'h1, 4'hF, 32'h0, 32'h0000_1122, 0};

        nrst = 1'b0;
        imem_ren = 1'b0; imem_addr = 32'h0;
        dmem_ren = 1'b0; dmem_wen = 1'b0; dmem_addr = 32'h0;
        dmem_width = 3'd0; dmem_store = 32'h0;
        ram_rdata = 32'h0; ram_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("reset hits", 32'({ihit, dhit, misalign_err, bus_err}), 32'd0);
        check("reset strobes", 32'({ram_ren, ram_wen}), 32'd0);
        check("reset ram_addr", 32'(ram_addr), 32'd0);
        check("reset ram_wdata", ram_wdata, 32'd0);
        check("reset ram_be", 32'(ram_be), 32'd0);
        check("reset imem_load", imem_load, 32'd0);
        check("reset dmem_load", dmem_load, 32'd0);
        nrst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // simultaneous fetch and load: data wins, fetch follows after one IDLE cycle
        imem_ren = 1'b1; imem_addr = 32'h0000_0800;
        dmem_ren = 1'b1; dmem_wen = 1'b0; dmem_addr = 32'h0000_0C00; dmem_width = 3'd2;
        @(negedge clk);
        check("arb first ram_addr", 32'(ram_addr), 32'h300);
        check("arb first ram_ren", 32'(ram_ren), 32'd1);
        ram_ready = 1'b1; ram_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        ram_ready = 1'b0;
        dmem_ren  = 1'b0;
        check("arb dhit", 32'({ihit, dhit}), 32'd1);
        check("arb dmem_load", dmem_load, 32'h0BAD_F00D);
        @(negedge clk);
        check("arb idle gap", 32'({ihit, dhit, ram_ren}), 32'd0);
        @(negedge clk);
        check("arb second ram_addr", 32'(ram_addr), 32'h200);
        check("arb second ram_ren", 32'(ram_ren), 32'd1);
        ram_ready = 1'b1; ram_rdata = 32'h0000_0093;
        @(negedge clk);
        ram_ready = 1'b0;
        imem_ren  = 1'b0;
        check("arb ihit", 32'({ihit, dhit}), 32'd2);
        check("arb imem_load", imem_load, 32'h0000_0093);
        @(negedge clk);

        // reset while a store is waiting on the RAM
        dmem_wen = 1'b1; dmem_addr = 32'h0000_0044; dmem_width = 3'd2; dmem_store = 32'h5555_AAAA;
        @(negedge clk);
        dmem_wen = 1'b0;
        check("rst mid wen before", 32'(ram_wen), 32'd1);
        #1 nrst = 1'b0;
        #1;
        check("rst mid strobes", 32'({ram_ren, ram_wen}), 32'd0);
        check("rst mid ram_addr", 32'(ram_addr), 32'd0);
        check("rst mid ram_be", 32'(ram_be), 32'd0);
        check("rst mid ram_wdata", ram_wdata, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        run_txn(vecs[0], "post rst");

        // random traffic against the lane model
        for (int i = 0; i < 60; i++) begin
            rv.is_fetch = ($urandom_range(0, 2) == 0);
            rv.addr     = $urandom;
            rv.width    = 3'($urandom_range(0, 7));
            rv.wen      = !rv.is_fetch && $urandom_range(0, 1) == 1;
            rv.ren      = !rv.is_fetch && (!rv.wen || $urandom_range(0, 1) == 1);
            rv.store    = $urandom;
            rv.rdata    = $urandom;
            rv.lat      = $urandom_range(1, 4);
            rv.e_addr   = rv.addr[31:2];
            size        = rv.is_fetch ? 4 : m_size(rv.width);
            off         = int'(rv.addr[1:0]);
            rv.e_mis    = !rv.is_fetch && (off % size != 0);
            rv.e_be     = rv.is_fetch ? 4'hF : m_be(size, off, rv.wen);
            rv.e_wdata  = m_wdata(rv.store, size);
            if (rv.is_fetch)  rv.e_load = rv.rdata;
            else if (rv.wen)  rv.e_load = 32'h0;
            else if (rv.e_mis) rv.e_load = 32'h0;
            else              rv.e_load = m_load(rv.rdata, size, off);
            run_txn(rv, $sformatf("rnd%0d", i));
        end

`ifdef MEM_ARBITER_TIMEOUT_EN
        // RAM never answers: abort after TIMEOUT_CYCLES=8 cycles in DBUSY
        dmem_ren = 1'b1; dmem_addr = 32'h0000_0010; dmem_width = 3'd2;
        hit_at = 0;
        for (int c = 1; c <= 20 && hit_at == 0; c++) begin
            @(negedge clk);
            dmem_ren = 1'b0;
            if (dhit) hit_at = c;
        end
        check("timeout latency", 32'(hit_at), 32'd9);
        check("timeout bus_err", 32'(bus_err), 32'd1);
        check("timeout dmem_load", dmem_load, 32'hDEAD_BEEF);
        check("timeout strobes", 32'({ram_ren, ram_wen}), 32'd0);
        @(negedge clk);
`else
        hit_at = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory responder that sits between the core datapath's instruction and data request ports and one backing RAM. It arbitrates between `imem_ren` and `dmem_ren`/`dmem_wen`, converts byte, halfword and word accesses into word-addressed RAM cycles with byte enables, and returns registered one-cycle `ihit`/`dhit` pulses with read data. It is the responder end of the datapath's `imem_*`/`dmem_*` handshake.

## Interface
- `DATA_PRIORITY`, 1: 1 = data request wins a simultaneous request; 0 = instruction wins.
- `TIMEOUT_CYCLES`, 64: watchdog limit in cycles. Used only with `MEM_ARBITER_TIMEOUT_EN`.
- `clk` in 1: clock, rising edge.
- `nrst` in 1: reset, asynchronous, active-low.
- `imem_ren` in 1: instruction fetch request.
- `imem_addr` in 32: fetch address. Bits [1:0] are ignored.
- `imem_load` out 32: fetched word. Valid while `ihit`=1.
- `ihit` out 1: fetch-complete pulse.
- `dmem_ren` in 1: data load request.
- `dmem_wen` in 1: data store request. If `dmem_ren` and `dmem_wen` are both high, the store is performed.
- `dmem_addr` in 32: byte address.
- `dmem_width` in 3: 000 = byte, 001 = half, 010 = word. Bit 2 is ignored. 11 in [1:0] is treated as word.
- `dmem_store` in 32: store data, right-aligned.
- `dmem_load` out 32: load data, right-aligned and zero-filled. Valid while `dhit`=1.
- `dhit` out 1: data-complete pulse.
- `misalign_err` out 1: pulses together with `dhit` on a misaligned data access.
- `bus_err` out 1: pulses together with the hit on a watchdog abort.
- `ram_addr` out 30: word address, equal to addr[31:2].
- `ram_ren` out 1: RAM read strobe.
- `ram_wen` out 1: RAM write strobe.
- `ram_wdata` out 32: lane-positioned write data.
- `ram_be` out 4: byte enables.
- `ram_rdata` in 32: RAM read word.
- `ram_ready` in 1: RAM access complete. Sampled on the rising edge.

## Operation
- FSM states: IDLE, IBUSY, DBUSY, RESP.
- IDLE:
  - Grants one pending request according to `DATA_PRIORITY`.
  - At grant, latches address, width, store data, direction and source. Request inputs are ignored until the FSM returns to IDLE.
  - A granted fetch goes to IBUSY.
  - An aligned data access goes to DBUSY.
  - A misaligned data access goes directly to RESP with `misalign_err`. No RAM strobe is issued.
- Misaligned access: half with addr[0]=1, or word with addr[1:0]≠0.
- IBUSY/DBUSY:
  - Drive the registered `ram_*` outputs and hold them stable until `ram_ready`=1 at a rising edge.
  - At that edge, capture read data into the response register and go to RESP.
- Byte lanes (off = addr[1:0]):
  - Byte: `ram_be`=1<<off; `ram_wdata` = store[7:0] replicated ×4.
  - Half: `ram_be`=0011 when off[1]=0, else 1100; `ram_wdata` = store[15:0] replicated ×2.
  - Word: `ram_be`=1111; `ram_wdata` = store.
  - Loads: `ram_be`=1111. The response is `ram_rdata` >> (8·off), masked to the access width, upper bits zero.
- RESP:
  - Lasts exactly one cycle. `ihit` or `dhit` (per latched source) = 1 with the response data.
  - Stores return `dmem_load`=0.
  - Next state is always IDLE.
  - A request still asserted in the IDLE cycle after RESP is treated as new.
- Output and response data registers hold their last value outside hit cycles. Reset value is 0.

## Timing
- Reset (asynchronous, any state, including mid-access): FSM → IDLE.
  - Outputs `ihit`, `dhit`, `misalign_err`, `bus_err`, `ram_ren`, `ram_wen` = 0, immediately.
  - `ram_addr`, `ram_wdata`, `ram_be`, `imem_load`, `dmem_load` = 0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Aligned access:
  - Request seen in IDLE at edge E0.
  - Strobe asserted E0→E1.
  - `ram_ready` sampled high at edge Ek (k≥1).
  - Hit asserted for the single cycle Ek→Ek+1.
  - Minimum latency is 2 cycles from request to hit.
- Misaligned access: hit and `misalign_err` asserted in the cycle after grant (latency 1).
- Back-to-back: IDLE always occupies at least one cycle between RESP and the next grant. Minimum throughput is one access per 3 cycles.
- A simultaneous fetch and data request serves the winner first. The loser is granted on its next IDLE cycle if it is still asserted.

## Configuration
- `MEM_ARBITER_TIMEOUT_EN` defined:
  - A watchdog counter clears at grant and increments in IBUSY/DBUSY.
  - When it reaches `TIMEOUT_CYCLES` without `ram_ready`, the strobes drop and the FSM goes to RESP with `bus_err`=1 and load data 0xDEAD_BEEF.
  - A `ram_ready` on the same edge as the limit wins, giving a normal response.
- Not defined:
  - No counter; the FSM waits in IBUSY/DBUSY indefinitely.
  - `bus_err` is tied to 0.

## Test plan
- Fetch word: `imem_addr`=0x100, RAM ready after 3 cycles with 0x0000_0013 → `ram_addr`=0x40, `ram_ren` held 3 cycles, one-cycle `ihit` with `imem_load`=0x0000_0013.
- Load byte: addr=0x203, width=000, `ram_rdata`=0xAABB_CCDD → `ram_be`=1111, `dmem_load`=0x0000_00AA; halfword at 0x202 → 0x0000_AABB.
- Store half: addr=0x302, width=001, store=0x1234_5678 → `ram_wen`, `ram_be`=1100, `ram_wdata`=0x5678_5678, `dhit` pulse with `dmem_load`=0.
- Misaligned word: addr=0x101, width=010 → no `ram_ren`/`ram_wen`, `dhit`+`misalign_err` the cycle after the request.
- Arbitration and reset:
  - Fetch and load requested together with `DATA_PRIORITY`=1 → load served first; fetch hit follows after an IDLE cycle.
  - `nrst` dropped mid-DBUSY → strobes fall immediately; the FSM restarts in IDLE.
- Timeout (macro on, `TIMEOUT_CYCLES`=8, `ram_ready` stuck low) → after 8 cycles in DBUSY, `dhit`+`bus_err`, `dmem_load`=0xDEAD_BEEF.
